// File: rtl/pearson_hash_sched_if.sv
// Handshake bundle for pearson_hash_sched: source streams, hash-engine port, tagged result.
// Latency: none; this is a wiring-only bundle.
// Backpressure: in_ready, core_ready and resp_ready carry the stall on each leg.
//
// Signals:
//   in_valid/in_data/in_last/in_ready : NUM_REQ byte-serial framed sources (source i in in_data[8i+7:8i])
//   grant                             : one-hot current owner, zero when idle
//   core_clear/core_valid/core_byte   : commands to the shared Pearson engine
//   core_ready/core_hash              : engine accept / running hash
//   resp_valid/resp_id/resp_hash/resp_err/resp_ready : per-message result
// Modports: master = scheduler side, slave = sources + engine + result consumer.
interface pearson_hash_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   in_valid;
    logic [NUM_REQ*8-1:0] in_data;
    logic [NUM_REQ-1:0]   in_last;
    logic [NUM_REQ-1:0]   in_ready;
    logic [NUM_REQ-1:0]   grant;

    logic                 core_clear;
    logic                 core_valid;
    logic [7:0]           core_byte;
    logic                 core_ready;
    logic [7:0]           core_hash;

    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic [7:0]           resp_hash;
    logic                 resp_err;
    logic                 resp_ready;

    modport master (
        input  in_valid, in_data, in_last, core_ready, core_hash, resp_ready,
        output in_ready, grant, core_clear, core_valid, core_byte,
               resp_valid, resp_id, resp_hash, resp_err
    );

    modport slave (
        output in_valid, in_data, in_last, core_ready, core_hash, resp_ready,
        input  in_ready, grant, core_clear, core_valid, core_byte,
               resp_valid, resp_id, resp_hash, resp_err
    );
endinterface

// File: rtl/pearson_hash_sched.sv
// Round-robin scheduler sharing one byte-serial Pearson hash engine among NUM_REQ framed sources.
// Latency: request sampled in IDLE -> first byte accepted 2 cycles later; core_ready seen in DRAIN -> resp_valid next cycle.
// Backpressure: core_ready feeds the owner's in_ready combinationally; resp_ready=0 holds the result and blocks re-arbitration.
//
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset; a reset mid-message drops it with no response
//   bus     : pearson_hash_sched_if.master (sources, engine port, result port)
// Optional build macro PEARSON_SCHED_TIMEOUT_EN: an owner that withholds in_valid for
// TIMEOUT STREAM cycles is aborted with resp_err=1 and resp_hash=8'h00. Without it,
// resp_err is constant 0 and a stalled owner keeps the grant indefinitely.
module pearson_hash_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    pearson_hash_sched_if.master bus
);

    if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("pearson_hash_sched: illegal NUM_REQ/ID_W/TIMEOUT combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESP
    } state_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    rr_ptr;
    logic               core_clear_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [7:0]         resp_hash_q;

`ifdef PEARSON_SCHED_TIMEOUT_EN
    localparam logic [15:0] STALL_LIM = 16'(TIMEOUT - 1);
    logic [15:0] stall_cnt;
    logic        resp_err_q;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: walk upward from rr_ptr with wrap, first request wins.
    // The candidate index is reduced modulo NUM_REQ explicitly so that
    // non-power-of-two NUM_REQ never probes a nonexistent source.
    // ------------------------------------------------------------------
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_W:0]      cand_sum;

    always_comb begin
        win_found  = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        cand_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            if (!win_found && bus.in_valid[cand_sum[ID_W-1:0]]) begin
                win_found                          = 1'b1;
                win_id                             = cand_sum[ID_W-1:0];
                win_onehot[cand_sum[ID_W-1:0]]     = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner's lane, selected by the one-hot grant (all zero while idle).
    // ------------------------------------------------------------------
    logic       own_valid;
    logic       own_last;
    logic [7:0] own_data;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_valid = bus.in_valid[i];
                own_last  = bus.in_last[i];
                own_data  = bus.in_data[i*8 +: 8];
            end
        end
    end

    // Streaming path is combinational so a byte crosses in the same cycle the
    // engine reports ready; everything else is registered.
    logic streaming;
    logic beat_xfer;

    assign streaming      = (state == S_STREAM);
    assign bus.in_ready   = (streaming && bus.core_ready) ? grant_q : '0;
    assign bus.core_valid = streaming && own_valid && bus.core_ready;
    assign bus.core_byte  = streaming ? own_data : 8'h00;
    assign beat_xfer      = bus.core_valid;

    assign bus.grant      = grant_q;
    assign bus.core_clear = core_clear_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_hash  = resp_hash_q;
`ifdef PEARSON_SCHED_TIMEOUT_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            grant_q      <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            core_clear_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_hash_q  <= 8'h00;
`ifdef PEARSON_SCHED_TIMEOUT_EN
            stall_cnt    <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            core_clear_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_q      <= win_onehot;
                        owner        <= win_id;
                        core_clear_q <= 1'b1;
                        state        <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    // core_clear is high for exactly this cycle.
                    state <= S_STREAM;
`ifdef PEARSON_SCHED_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                end

                S_STREAM: begin
                    if (beat_xfer && own_last) begin
                        state <= S_DRAIN;
                    end
`ifdef PEARSON_SCHED_TIMEOUT_EN
                    // Only source-side stalls count; core_ready=0 with data
                    // pending neither advances nor clears the counter.
                    if (beat_xfer) begin
                        stall_cnt <= '0;
                    end else if (!own_valid) begin
                        if (stall_cnt == STALL_LIM) begin
                            state        <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_hash_q  <= 8'h00;
                            resp_id_q    <= owner;
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
`endif
                end

                S_DRAIN: begin
                    // core_ready here means the last byte is folded into core_hash.
                    if (bus.core_ready) begin
                        resp_hash_q  <= bus.core_hash;
                        resp_id_q    <= owner;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        grant_q      <= '0;
                        rr_ptr       <= (owner == LAST_ID) ? '0 : owner + ID_W'(1);
                        state        <= S_IDLE;
`ifdef PEARSON_SCHED_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pearson_hash_sched.sv
// Bench for pearson_hash_sched: scoreboard of expected (id, hash, err, beats) per message.
// Latency: checks are event-driven on the response handshake, not cycle-exact.
// Backpressure: core_ready and resp_ready are driven from patterns or random percentages.
module tb_pearson_hash_sched;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     hash;
        logic           err;
        logic [7:0]     len;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    pearson_hash_sched_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

    pearson_hash_sched #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int compared = 0;
    int fails    = 0;

    logic [7:0] msg_q [N][$];
    bit         presented [N];
    bit         started [N];
    bit         noend [N];
    bit         drv_en;
    int         gap_pct;
    int         core_pct;
    int         resp_pct;
    bit         core_pat [$];
    exp_t       sb [$];
    int         m_ptr;
    logic [7:0] core_h;
    logic [7:0] tmp_b [$];
    int         beat_cnt;
    bit         held;
    bit         post_hs;
    logic [IDW-1:0] h_id;
    logic [7:0]     h_hash;
    logic [N-1:0]   h_grant;
    exp_t       mon_e;
    int         rv_seen;

    // Pearson permutation table: odd multiplier mod 256 is a bijection.
    function automatic logic [7:0] ptab(input logic [7:0] x);
        logic [15:0] t;
        t = {8'h00, x} * 16'd167 + 16'd13;
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- engine model ----------------
    always @(posedge clock) begin
        if (bus.core_clear) core_h <= 8'h00;
        else if (bus.core_valid && bus.core_ready) core_h <= ptab(core_h ^ bus.core_byte);
    end
    assign bus.core_hash = core_h;

    // ---------------- core_ready / resp_ready drivers ----------------
    initial begin : rdy_drv
        bus.core_ready = 1'b0;
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (core_pat.size() > 0) bus.core_ready = core_pat.pop_front();
            else bus.core_ready = ($urandom_range(99) < core_pct);
            bus.resp_ready = ($urandom_range(99) < resp_pct);
        end
    end

    // ---------------- source drivers ----------------
    initial begin : src_drv
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_last  = '0;
        forever begin
            @(posedge clock); #1;
            for (int s = 0; s < N; s++) begin
                if (!drv_en) begin
                    bus.in_valid[s] = 1'b0;
                    bus.in_last[s]  = 1'b0;
                end else begin
                    // First byte of a message is never delayed so simultaneous
                    // requests really are simultaneous; later bytes may gap.
                    if (!presented[s] && msg_q[s].size() > 0 &&
                        (!started[s] || $urandom_range(99) >= gap_pct))
                        presented[s] = 1'b1;
                    bus.in_valid[s]        = presented[s];
                    bus.in_data[s*8 +: 8]  = presented[s] ? msg_q[s][0] : 8'($urandom);
                    bus.in_last[s]         = presented[s] && msg_q[s].size() == 1 && !noend[s];
                end
            end
        end
    end

    initial begin : src_acc
        forever begin
            @(negedge clock);
            for (int s = 0; s < N; s++) begin
                if (drv_en && presented[s] && bus.in_valid[s] && bus.in_ready[s]) begin
                    void'(msg_q[s].pop_front());
                    presented[s] = 1'b0;
                    started[s]   = (msg_q[s].size() > 0);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        held = 0; post_hs = 0; beat_cnt = 0; rv_seen = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                held = 0; post_hs = 0; beat_cnt = 0;
            end else begin
                if (bus.resp_valid) rv_seen++;
                if (post_hs) begin
                    chk("idle_grant", 32'(bus.grant), 32'd0);
                    chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
                    post_hs = 0;
                end
                if (held) begin
                    chk("hold_valid", 32'(bus.resp_valid), 32'd1);
                    chk("hold_id", 32'(bus.resp_id), 32'(h_id));
                    chk("hold_hash", 32'(bus.resp_hash), 32'(h_hash));
                    chk("hold_grant", 32'(bus.grant), 32'(h_grant));
                end
                if (bus.core_clear) beat_cnt = 0;
                if (bus.core_valid) beat_cnt++;
                if (bus.resp_valid) begin
                    if (bus.resp_ready) begin
                        if (sb.size() == 0) begin
                            compared++; fails++;
                            $display("FAIL unexpected_resp: got id %0d hash 0x%02h, expected no response",
                                     bus.resp_id, bus.resp_hash);
                        end else begin
                            mon_e = sb.pop_front();
                            chk("resp_id", 32'(bus.resp_id), 32'(mon_e.id));
                            chk("resp_hash", 32'(bus.resp_hash), 32'(mon_e.hash));
                            chk("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                            chk("beat_count", 32'(beat_cnt), 32'(mon_e.len));
                        end
                        held = 0; post_hs = 1;
                    end else begin
                        held = 1;
                        h_id = bus.resp_id; h_hash = bus.resp_hash; h_grant = bus.grant;
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Messages must be queued in the order the arbiter will serve them; the
    // model pointer tracks the round-robin start for that ordering.
    task automatic queue_msg(input int s, input logic [7:0] b[$], input bit trunc);
        exp_t e;
        logic [7:0] h;
        h = 8'h00;
        foreach (b[i]) begin
            msg_q[s].push_back(b[i]);
            h = ptab(h ^ b[i]);
        end
        noend[s] = trunc;
        e.id   = IDW'(s);
        e.hash = trunc ? 8'h00 : h;
        e.err  = trunc;
        e.len  = 8'(b.size());
        sb.push_back(e);
        m_ptr = (s + 1) % N;
    endtask

    task automatic run_round(input logic [N-1:0] mask, input int maxlen);
        int start;
        start = m_ptr;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (start + k) % N;
            if (mask[s]) begin
                tmp_b.delete();
                for (int j = 0; j < $urandom_range(maxlen, 1); j++) tmp_b.push_back(8'($urandom));
                queue_msg(s, tmp_b, 1'b0);
            end
        end
    endtask

    function automatic bit all_empty();
        for (int s = 0; s < N; s++)
            if (msg_q[s].size() != 0 || presented[s]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #3;
            if (sb.size() == 0 && all_empty()) begin
                @(negedge clock); #1;
                return;
            end
        end
        compared++; fails++;
        $display("FAIL %s_timeout: %0d responses still pending, expected 0", name, sb.size());
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_in_ready"},   32'(bus.in_ready),   32'd0);
        chk({name, "_grant"},      32'(bus.grant),      32'd0);
        chk({name, "_core_clear"}, 32'(bus.core_clear), 32'd0);
        chk({name, "_core_valid"}, 32'(bus.core_valid), 32'd0);
        chk({name, "_core_byte"},  32'(bus.core_byte),  32'd0);
        chk({name, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({name, "_resp_id"},    32'(bus.resp_id),    32'd0);
        chk({name, "_resp_hash"},  32'(bus.resp_hash),  32'd0);
        chk({name, "_resp_err"},   32'(bus.resp_err),   32'd0);
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        drv_en  = 1'b0;
        @(posedge clock); #2;
        for (int s = 0; s < N; s++) begin
            msg_q[s].delete();
            presented[s] = 0; started[s] = 0; noend[s] = 0;
        end
        sb.delete();
        core_pat.delete();
        m_ptr = 0;
        @(negedge clock);
        check_reset_outputs(name);
        @(posedge clock); #2;
        reset_n = 1'b1;
        drv_en  = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        reset_n = 1'b0; drv_en = 1'b0;
        gap_pct = 0; core_pct = 100; resp_pct = 100; m_ptr = 0;
        for (int s = 0; s < N; s++) begin presented[s] = 0; started[s] = 0; noend[s] = 0; end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        @(posedge clock); #2;
        reset_n = 1'b1; drv_en = 1'b1;

        // Single source, two bytes.
        tmp_b = {8'h41, 8'h42};
        queue_msg(0, tmp_b, 1'b0);
        wait_idle("single");

        // Contention from reset: two rounds, one byte each, order 0..3 twice.
        do_reset("rst2");
        run_round(4'hF, 1);
        wait_idle("cont1");
        run_round(4'hF, 1);
        wait_idle("cont2");

        // Engine backpressure during source 2's 3-byte message.
        tmp_b = {8'h10, 8'h20, 8'h30};
        queue_msg(2, tmp_b, 1'b0);
        begin : wait_g2
            bit seen;
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clock);
                if (bus.grant[2]) seen = 1;
            end
            chk("bp_grant2_seen", 32'(seen), 32'd1);
        end
        core_pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        wait_idle("bp");

        // Response stall with a second source waiting.
        resp_pct = 0;
        tmp_b = {8'hA5, 8'h5A};
        queue_msg(3, tmp_b, 1'b0);
        tmp_b = {8'hFF};
        queue_msg(1, tmp_b, 1'b0);
        begin : wait_rv
            bit seen;
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clock);
                if (bus.resp_valid) seen = 1;
            end
            chk("stall_resp_seen", 32'(seen), 32'd1);
        end
        repeat (5) @(negedge clock);
        resp_pct = 100;
        wait_idle("stall");

        // Reset in the middle of source 1's second byte; no response may follow.
        do_reset("rst3");
        tmp_b = {8'h01, 8'h02, 8'h03};
        queue_msg(1, tmp_b, 1'b0);
        begin : wait_b2
            bit seen;
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(posedge clock); #3;
                if (presented[1] && msg_q[1].size() == 2) seen = 1;
            end
            chk("mid_byte2_seen", 32'(seen), 32'd1);
        end
        do_reset("midrst");
        rv_seen = 0;
        repeat (6) @(negedge clock);
        chk("mid_no_resp", 32'(rv_seen), 32'd0);
        tmp_b = {8'h33, 8'h44};
        queue_msg(3, tmp_b, 1'b0);
        wait_idle("after_rst");

`ifdef PEARSON_SCHED_TIMEOUT_EN
        // Owner 0 stops after one byte without last; source 1 is served next.
        do_reset("rst4");
        tmp_b = {8'h77};
        queue_msg(0, tmp_b, 1'b1);
        tmp_b = {8'h12, 8'h34};
        queue_msg(1, tmp_b, 1'b0);
        wait_idle("timeout");
`endif

        // Randomized rounds with gaps and random backpressure on both sides.
        gap_pct = 30; core_pct = 70; resp_pct = 60;
        for (int r = 0; r < 30; r++) begin
            run_round(N'($urandom_range(15, 1)), 6);
            wait_idle("rand");
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
